// File: rtl/fpu_int_to_f32_pipe.sv
// Purpose : pipelined integer -> IEEE-754 binary32 converter, round to nearest even.
// Latency : 3 cycles from input acceptance to o_valid when unstalled; 1 result/cycle sustained.
// Backpr. : each stage advances when empty or when the next stage advances; o_ready=0 holds S3.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   i_valid/i_ready       operand handshake; i_signed selects two's complement vs unsigned
//   i_a, i_tag            integer operand (IN_WIDTH bits) and opaque tag
//   o_valid/o_ready       result handshake
//   o_f, o_tag            binary32 result and the tag that came in with its operand
//   o_inexact             rounding discarded nonzero bits; only driven when FPU_I2F_FLAGS_EN
//                         is defined, otherwise tied to 0
//
// Stages:
//   S1: sign extraction and magnitude (absolute value as unsigned)
//   S2: leading-one detect, left-normalise, biased exponent
//   S3: round to nearest even on the bits below the 24-bit significand, pack

module fpu_int_to_f32_pipe #(
  parameter int IN_WIDTH  = 32,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic                 i_signed,
  input  logic [IN_WIDTH-1:0]  i_a,
  input  logic [TAG_WIDTH-1:0] i_tag,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [31:0]          o_f,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic                 o_inexact
);

  // The normalised value is viewed through a window at least 26 bits wide so that
  // hidden bit, 23 fraction bits, guard bit and at least one sticky bit always exist.
  // For IN_WIDTH <= 24 the guard/sticky bits are constant zero and rounding folds away.
  localparam int PW = (IN_WIDTH < 26) ? 26 : IN_WIDTH;
  localparam int SH = PW - IN_WIDTH;

  // ---------------------------------------------------------------- stage control
  logic ld1, ld2, ld3;

  logic                 s1_vld;
  logic                 s1_sign;
  logic [IN_WIDTH-1:0]  s1_mag;
  logic [TAG_WIDTH-1:0] s1_tag;

  logic                 s2_vld;
  logic                 s2_sign;
  logic [IN_WIDTH-1:0]  s2_norm;
  logic [7:0]           s2_exp;
  logic [TAG_WIDTH-1:0] s2_tag;

  assign ld3     = !o_valid || o_ready;
  assign ld2     = !s2_vld || ld3;
  assign ld1     = !s1_vld || ld2;
  assign i_ready = ld1;

  // ---------------------------------------------------------------- S1: sign / magnitude
  logic                s1_sign_d;
  logic [IN_WIDTH-1:0] s1_mag_d;

  // For the signed minimum, -A wraps back to 2^(IN_WIDTH-1), which is the correct
  // magnitude when read as unsigned.
  assign s1_sign_d = i_signed & i_a[IN_WIDTH-1];
  assign s1_mag_d  = s1_sign_d ? -i_a : i_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag  <= '0;
      s1_tag  <= '0;
    end else if (ld1) begin
      s1_vld <= i_valid;
      if (i_valid) begin
        s1_sign <= s1_sign_d;
        s1_mag  <= s1_mag_d;
        s1_tag  <= i_tag;
      end
    end
  end

  // ---------------------------------------------------------------- S2: LOD / normalise
  logic [6:0]          lead;
  logic [IN_WIDTH-1:0] s2_norm_d;
  logic [7:0]          s2_exp_d;

  // Highest set bit wins; a zero magnitude leaves lead=0 and norm=0, which S3 detects
  // through the missing hidden bit.
  always_comb begin
    lead = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (s1_mag[i]) lead = 7'(i);
    end
  end

  assign s2_norm_d = s1_mag << (7'(IN_WIDTH - 1) - lead);
  assign s2_exp_d  = 8'd127 + {1'b0, lead};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_vld  <= 1'b0;
      s2_sign <= 1'b0;
      s2_norm <= '0;
      s2_exp  <= '0;
      s2_tag  <= '0;
    end else if (ld2) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_sign <= s1_sign;
        s2_norm <= s2_norm_d;
        s2_exp  <= s2_exp_d;
        s2_tag  <= s1_tag;
      end
    end
  end

  // ---------------------------------------------------------------- S3: round / pack
  logic [PW-1:0] ext;
  logic          nz;
  logic [22:0]   frac_t;
  logic          guard;
  logic          sticky;
  logic          rnd_up;
  logic [30:0]   body;
  logic [31:0]   f_d;

  assign ext    = PW'(s2_norm) << SH;
  assign nz     = ext[PW-1];
  assign frac_t = ext[PW-2 -: 23];
  assign guard  = ext[PW-25];
  assign sticky = |ext[PW-26:0];
  assign rnd_up = guard & (sticky | frac_t[0]);

  // Adding the round increment across {exp, frac} lets a fraction carry-out bump the
  // exponent and leave an all-zero fraction, which is exactly the next power of two.
  assign body = {s2_exp, frac_t} + {30'd0, rnd_up};
  assign f_d  = nz ? {s2_sign, body} : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_f     <= '0;
      o_tag   <= '0;
    end else if (ld3) begin
      o_valid <= s2_vld;
      if (s2_vld) begin
        o_f   <= f_d;
        o_tag <= s2_tag;
      end
    end
  end

`ifdef FPU_I2F_FLAGS_EN
  logic inexact_d;

  assign inexact_d = guard | sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_inexact <= 1'b0;
    end else if (ld3 && s2_vld) begin
      o_inexact <= inexact_d;
    end
  end
`else
  assign o_inexact = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_int_to_f32_pipe.sv
// Bench for fpu_int_to_f32_pipe: fixed vectors with known results, wide/narrow
// instances, a randomized back-pressured stream against an arithmetic reference,
// and a reset issued while operands are in flight.

module tb_fpu_int_to_f32_pipe;

`ifdef FPU_I2F_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, i_signed;
  logic [31:0] i_a;
  logic [3:0]  i_tag;
  logic        o_valid, o_ready;
  logic [31:0] o_f;
  logic [3:0]  o_tag;
  logic        o_inexact;

  logic        v64_iv, v64_ir, v64_sg, v64_ov, v64_x;
  logic [63:0] v64_a;
  logic [31:0] v64_f;
  logic [3:0]  v64_t;
  logic        v16_iv, v16_ir, v16_sg, v16_ov, v16_x;
  logic [15:0] v16_a;
  logic [31:0] v16_f;
  logic [3:0]  v16_t;

  always #5 clk = ~clk;

  fpu_int_to_f32_pipe #(.IN_WIDTH(32), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_signed(i_signed),
    .i_a(i_a), .i_tag(i_tag), .o_valid(o_valid), .o_ready(o_ready), .o_f(o_f),
    .o_tag(o_tag), .o_inexact(o_inexact));

  fpu_int_to_f32_pipe #(.IN_WIDTH(64), .TAG_WIDTH(4)) dut64 (
    .clk(clk), .rst(rst), .i_valid(v64_iv), .i_ready(v64_ir), .i_signed(v64_sg),
    .i_a(v64_a), .i_tag(4'd5), .o_valid(v64_ov), .o_ready(1'b1), .o_f(v64_f),
    .o_tag(v64_t), .o_inexact(v64_x));

  fpu_int_to_f32_pipe #(.IN_WIDTH(16), .TAG_WIDTH(4)) dut16 (
    .clk(clk), .rst(rst), .i_valid(v16_iv), .i_ready(v16_ir), .i_signed(v16_sg),
    .i_a(v16_a), .i_tag(4'd6), .o_valid(v16_ov), .o_ready(1'b1), .o_f(v16_f),
    .o_tag(v16_t), .o_inexact(v16_x));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: exact integer magnitude, floor(log2), then quotient/remainder rounding.
  // Returns {inexact, f}.
  function automatic logic [32:0] ref_cvt(input logic sg, input logic [31:0] a);
    longint unsigned m, q, r, half;
    logic s;
    int e;
    s = sg & a[31];
    m = s ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
    if (m == 0) return 33'd0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = m << (23 - e);
      r = 0;
    end else begin
      q    = m >> (e - 23);
      r    = m - (q << (e - 23));
      half = 64'd1 << (e - 24);
      if (r > half || (r == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {r != 0, s, 8'(e + 127), q[22:0]};
  endfunction

  typedef struct { logic [31:0] f; logic inx; logic [3:0] tag; } exp_t;
  exp_t q[$];

  logic        sb_on, rdy_chk, acc, hold_pend;
  logic [31:0] hold_f;
  logic [3:0]  hold_tag;
  int          retired;

  // One clock: sample everything at the falling edge, then return just after the rising edge.
  task automatic tick();
    logic [32:0] res;
    exp_t ex;
    @(negedge clk);
    acc = i_valid && i_ready;
    if (sb_on) begin
      if (rdy_chk) chk("i_ready_vs_full_stall", 64'(i_ready), 64'(!(q.size() == 3 && !o_ready)));
      if (hold_pend) begin
        chk("hold_valid", 64'(o_valid), 64'(1));
        chk("hold_f", 64'(o_f), 64'(hold_f));
        chk("hold_tag", 64'(o_tag), 64'(hold_tag));
      end
      if (q.size() == 0) begin
        chk("out_when_empty", 64'(o_valid), 64'(0));
      end else if (o_valid && o_ready) begin
        ex = q.pop_front();
        chk("stream_f", 64'(o_f), 64'(ex.f));
        chk("stream_tag", 64'(o_tag), 64'(ex.tag));
        chk("stream_inexact", 64'(o_inexact), 64'(ex.inx));
        retired++;
      end
      if (acc) begin
        res    = ref_cvt(i_signed, i_a);
        ex.f   = res[31:0];
        ex.inx = FLAGS & res[32];
        ex.tag = i_tag;
        q.push_back(ex);
      end
      hold_pend = o_valid && !o_ready;
      hold_f    = o_f;
      hold_tag  = o_tag;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op();
    case ($urandom_range(0, 4))
      0: i_a = $urandom;
      1: i_a = 32'($urandom_range(0, 300));
      2: i_a = 32'h8000_0000;
      3: i_a = 32'h0100_0000 + 32'($urandom_range(0, 7));
      default: i_a = $urandom | 32'hFF00_0000;
    endcase
    i_signed = 1'($urandom_range(0, 1));
  endtask

  typedef struct { logic sg; logic [31:0] a; logic [31:0] f; logic inx; } vec_t;
  localparam int NV = 14;
  vec_t tbl[NV];

  initial begin
    int lat, sent, cyc;
    logic got, got64, got16;
    logic [31:0] f64, f16;
    logic [3:0]  t64, t16;
    logic        x64, x16;

    tbl[0]  = '{1'b1, 32'h0000_0001, 32'h3F80_0000, 1'b0};
    tbl[1]  = '{1'b1, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0};
    tbl[2]  = '{1'b1, 32'h8000_0000, 32'hCF00_0000, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[4]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[5]  = '{1'b0, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b1};
    tbl[6]  = '{1'b0, 32'h0100_0001, 32'h4B80_0000, 1'b1};
    tbl[7]  = '{1'b0, 32'h0100_0003, 32'h4B80_0002, 1'b1};
    tbl[8]  = '{1'b0, 32'h00FF_FFFF, 32'h4B7F_FFFF, 1'b0};
    tbl[9]  = '{1'b1, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b1};
    tbl[10] = '{1'b0, 32'h8000_0000, 32'h4F00_0000, 1'b0};
    tbl[11] = '{1'b1, 32'hFFFF_FF00, 32'hC380_0000, 1'b0};
    tbl[12] = '{1'b0, 32'h0100_0002, 32'h4B80_0001, 1'b0};
    tbl[13] = '{1'b0, 32'h0200_0006, 32'h4C00_0002, 1'b1};

    rst = 1'b1; i_valid = 1'b0; i_signed = 1'b0; i_a = '0; i_tag = '0; o_ready = 1'b0;
    v64_iv = 1'b0; v64_sg = 1'b0; v64_a = '0; v16_iv = 1'b0; v16_sg = 1'b0; v16_a = '0;
    sb_on = 1'b0; rdy_chk = 1'b0; acc = 1'b0; hold_pend = 1'b0; hold_f = '0; hold_tag = '0;
    retired = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_o_valid", 64'(o_valid), 64'(0));
    chk("rst_o_f", 64'(o_f), 64'(0));
    chk("rst_o_tag", 64'(o_tag), 64'(0));
    chk("rst_o_inexact", 64'(o_inexact), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_i_ready", 64'(i_ready), 64'(1));
    chk("rst_w64_i_ready", 64'(v64_ir), 64'(1));
    chk("rst_w16_i_ready", 64'(v16_ir), 64'(1));

    // Fixed vectors: one at a time, latency measured from the accepting cycle
    for (int k = 0; k < NV; k++) begin
      @(posedge clk); #1;
      i_valid = 1'b1; i_signed = tbl[k].sg; i_a = tbl[k].a; i_tag = 4'(k); o_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_accept", k), 64'(i_ready), 64'(1));
      @(posedge clk); #1;
      i_valid = 1'b0;
      lat = 0; got = 1'b0;
      while (!got && lat < 10) begin
        @(negedge clk);
        lat++;
        if (o_valid) got = 1'b1;
      end
      chk($sformatf("vec%0d_latency", k), 64'(lat), 64'(3));
      chk($sformatf("vec%0d_f", k), 64'(o_f), 64'(tbl[k].f));
      chk($sformatf("vec%0d_tag", k), 64'(o_tag), 64'(k));
      chk($sformatf("vec%0d_inexact", k), 64'(o_inexact), 64'(FLAGS & tbl[k].inx));
    end

    // 64-bit and 16-bit widths
    @(posedge clk); #1;
    v64_iv = 1'b1; v64_sg = 1'b0; v64_a = '1;
    v16_iv = 1'b1; v16_sg = 1'b1; v16_a = 16'h8000;
    @(negedge clk);
    chk("w64_accept", 64'(v64_ir), 64'(1));
    chk("w16_accept", 64'(v16_ir), 64'(1));
    @(posedge clk); #1;
    v64_iv = 1'b0; v16_iv = 1'b0;
    got64 = 1'b0; got16 = 1'b0;
    f64 = '0; f16 = '0; t64 = '0; t16 = '0; x64 = 1'b0; x16 = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (v64_ov && !got64) begin got64 = 1'b1; f64 = v64_f; t64 = v64_t; x64 = v64_x; end
      if (v16_ov && !got16) begin got16 = 1'b1; f16 = v16_f; t16 = v16_t; x16 = v16_x; end
    end
    chk("w64_seen", 64'(got64), 64'(1));
    chk("w64_f", 64'(f64), 64'h5F80_0000);
    chk("w64_tag", 64'(t64), 64'(5));
    chk("w64_inexact", 64'(x64), 64'(FLAGS));
    chk("w16_seen", 64'(got16), 64'(1));
    chk("w16_f", 64'(f16), 64'hC700_0000);
    chk("w16_tag", 64'(t16), 64'(6));
    chk("w16_inexact", 64'(x16), 64'(0));
    @(posedge clk); #1;

    // Randomized stream under random back-pressure; operand may change while stalled
    sb_on = 1'b1; rdy_chk = 1'b1; retired = 0; sent = 0; cyc = 0;
    while (retired < 16 && cyc < 3000) begin
      if (!i_valid && sent < 16 && $urandom_range(0, 3) != 0) begin
        i_valid = 1'b1;
        i_tag   = 4'(sent);
        rand_op();
      end else if (i_valid && $urandom_range(0, 1) == 1) begin
        rand_op();
      end
      o_ready = ($urandom_range(0, 9) < 6);
      tick();
      if (acc) begin
        sent++;
        i_valid = 1'b0;
      end
      cyc++;
    end
    chk("stream_sent", 64'(sent), 64'(16));
    chk("stream_retired", 64'(retired), 64'(16));
    o_ready = 1'b1;
    repeat (5) tick();
    chk("stream_queue_empty", 64'(q.size()), 64'(0));

    // Reset with three operands in flight
    o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1;
      i_tag   = 4'(k);
      rand_op();
      tick();
      chk($sformatf("prerst_accept%0d", k), 64'(acc), 64'(1));
    end
    i_valid = 1'b0;
    rst = 1'b1; rdy_chk = 1'b0;
    @(negedge clk);
    chk("midrst_o_valid", 64'(o_valid), 64'(0));
    chk("midrst_o_f", 64'(o_f), 64'(0));
    chk("midrst_o_tag", 64'(o_tag), 64'(0));
    q.delete();
    hold_pend = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; rdy_chk = 1'b1;
    retired = 0; sent = 0; cyc = 0;
    while (retired < 3 && cyc < 500) begin
      if (!i_valid && sent < 3) begin
        i_valid = 1'b1;
        i_tag   = 4'(8 + sent);
        rand_op();
      end
      o_ready = 1'($urandom_range(0, 1));
      tick();
      if (acc) begin
        sent++;
        i_valid = 1'b0;
      end
      cyc++;
    end
    o_ready = 1'b1;
    repeat (6) tick();
    chk("postrst_retired", 64'(retired), 64'(3));
    chk("postrst_queue_empty", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
